// File: rtl/any1_fu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : any1_fu_dispatch
// Description : Dispatch controller between the instruction scheduler and the
//               four functional units (ALU0, ALU1, MEM, FPU).
//               Each unit owns a 2-deep FIFO of ROB indexes and a two-state
//               go/done sequencer with a per-unit watchdog.
// Ports       : clk, rst_n              - clock, async active-low reset
//               sel_v/sel_rid/sel_unit  - one scheduler selection per cycle
//               flush                   - discard queued and in-flight work
//               fu_done[3:0]            - per-unit completion pulse
//               fu_full[3:0]            - per-unit FIFO holds 2 entries
//               issued_v/issued_rid     - selection accepted last cycle
//               sel_nack/nack_rid       - selection rejected (FIFO full)
//               fu_go[3:0]/fu_rid[23:0] - unit start pulse / held ROB index
//               cmp_v/cmp_err/cmp_rid   - completion report (err = timeout)
//               fu_timeout[3:0]         - sticky per-unit timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module any1_fu_dispatch #(
  parameter int          ROB_ENTRIES = 64,
  parameter logic [7:0]  TIMEOUT     = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_v,
  input  logic [5:0]  sel_rid,
  input  logic [1:0]  sel_unit,
  input  logic        flush,
  input  logic [3:0]  fu_done,
  output logic [3:0]  fu_full,
  output logic        issued_v,
  output logic [5:0]  issued_rid,
  output logic        sel_nack,
  output logic [5:0]  nack_rid,
  output logic [3:0]  fu_go,
  output logic [23:0] fu_rid,
  output logic [3:0]  cmp_v,
  output logic [3:0]  cmp_err,
  output logic [23:0] cmp_rid,
  output logic [3:0]  fu_timeout
);

  localparam logic [6:0] c_ROB_DEPTH = 7'(ROB_ENTRIES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } unit_state_t;

  // Pre-edge FIFO occupancy of every unit, gathered for the accept decision.
  logic [3:0][1:0] w_count;

  logic w_rid_ok;
  logic w_sel_full;
  logic w_accept;
  logic w_reject;

  // Indexes beyond a reduced ROB depth cannot name a real entry; with the
  // default 64-entry ROB every 6-bit index is in range.
  assign w_rid_ok   = ({1'b0, sel_rid} < c_ROB_DEPTH);
  assign w_sel_full = (w_count[sel_unit] == 2'd2);
  assign w_accept   = sel_v && !flush && w_rid_ok && !w_sel_full;
  assign w_reject   = sel_v && !flush && w_rid_ok &&  w_sel_full;

  // --------------------------------------------------------------------------
  // Accept / reject report to the ROB and scheduler
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_v   <= 1'b0;
      issued_rid <= 6'd0;
      sel_nack   <= 1'b0;
      nack_rid   <= 6'd0;
    end else begin
      issued_v <= w_accept;
      sel_nack <= w_reject;
      if (w_accept) issued_rid <= sel_rid;
      if (w_reject) nack_rid   <= sel_rid;
    end
  end

  // --------------------------------------------------------------------------
  // Per-unit FIFO, sequencer and watchdog
  // --------------------------------------------------------------------------
  for (genvar u = 0; u < 4; u++) begin : g_unit
    logic [1:0][5:0] r_mem;
    logic            r_head;
    logic            r_tail;
    logic [1:0]      r_count;
    unit_state_t     r_state;
    logic            r_discard;
    logic [7:0]      r_wd;
    logic            r_full;
    logic            r_go;
    logic [5:0]      r_fu_rid;
    logic            r_cmp_v;
    logic            r_cmp_err;
    logic [5:0]      r_cmp_rid;
    logic            r_timeout;

    logic            w_push;
    logic            w_pop;
    logic            w_finish;
    logic [5:0]      w_head_rid;
    logic [1:0]      w_count_next;

    assign w_push = w_accept && (sel_unit == 2'(u));
    // An idle unit with an empty FIFO starts straight from the incoming
    // selection, so the push and pop of the same entry share one edge.
    assign w_pop      = (r_state == ST_IDLE) && !flush && ((r_count != 2'd0) || w_push);
    assign w_head_rid = (r_count == 2'd0) ? sel_rid : r_mem[r_head];
    // A done takes precedence over a watchdog expiry on the same edge.
    assign w_finish   = fu_done[u] || (r_wd == TIMEOUT);

    always_comb begin
      w_count_next = r_count;
      if (flush) begin
        w_count_next = 2'd0;
      end else if (w_push && !w_pop) begin
        w_count_next = r_count + 2'd1;
      end else if (!w_push && w_pop) begin
        w_count_next = r_count - 2'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mem     <= '0;
        r_head    <= 1'b0;
        r_tail    <= 1'b0;
        r_count   <= 2'd0;
        r_state   <= ST_IDLE;
        r_discard <= 1'b0;
        r_wd      <= 8'd0;
        r_full    <= 1'b0;
        r_go      <= 1'b0;
        r_fu_rid  <= 6'd0;
        r_cmp_v   <= 1'b0;
        r_cmp_err <= 1'b0;
        r_cmp_rid <= 6'd0;
        r_timeout <= 1'b0;
      end else begin
        r_go      <= 1'b0;
        r_cmp_v   <= 1'b0;
        r_cmp_err <= 1'b0;
        r_count   <= w_count_next;
        r_full    <= (w_count_next == 2'd2);

        if (flush) begin
          r_head <= 1'b0;
          r_tail <= 1'b0;
        end else begin
          if (w_push) begin
            r_mem[r_tail] <= sel_rid;
            r_tail        <= ~r_tail;
          end
          if (w_pop) r_head <= ~r_head;
        end

        case (r_state)
          ST_IDLE: begin
            if (w_pop) begin
              r_state  <= ST_BUSY;
              r_go     <= 1'b1;
              r_fu_rid <= w_head_rid;
              r_wd     <= 8'd0;
            end
          end
          ST_BUSY: begin
            if (w_finish) begin
              r_state <= ST_IDLE;
              // Only a discard latched by an earlier flush suppresses the
              // report; a flush on this very edge does not.
              if (!r_discard) begin
                r_cmp_v   <= 1'b1;
                r_cmp_err <= !fu_done[u];
                r_cmp_rid <= r_fu_rid;
              end
              if (!fu_done[u]) r_timeout <= 1'b1;
              r_discard <= 1'b0;
            end else begin
              // r_wd < TIMEOUT here, so the increment saturates at TIMEOUT.
              r_wd <= r_wd + 8'd1;
              if (flush) r_discard <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end

    assign w_count[u]          = r_count;
    assign fu_full[u]          = r_full;
    assign fu_go[u]            = r_go;
    assign fu_rid[6*u +: 6]    = r_fu_rid;
    assign cmp_v[u]            = r_cmp_v;
    assign cmp_err[u]          = r_cmp_err;
    assign cmp_rid[6*u +: 6]   = r_cmp_rid;
    assign fu_timeout[u]       = r_timeout;
  end

endmodule
`default_nettype wire

// File: tb/tb_any1_fu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_any1_fu_dispatch
// Description : Directed self-checking bench for any1_fu_dispatch.
//               DUT is built with TIMEOUT = 4 so the watchdog abort is short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_any1_fu_dispatch;

  logic        clk;
  logic        rst_n;
  logic        sel_v;
  logic [5:0]  sel_rid;
  logic [1:0]  sel_unit;
  logic        flush;
  logic [3:0]  fu_done;
  logic [3:0]  fu_full;
  logic        issued_v;
  logic [5:0]  issued_rid;
  logic        sel_nack;
  logic [5:0]  nack_rid;
  logic [3:0]  fu_go;
  logic [23:0] fu_rid;
  logic [3:0]  cmp_v;
  logic [3:0]  cmp_err;
  logic [23:0] cmp_rid;
  logic [3:0]  fu_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  any1_fu_dispatch #(
    .ROB_ENTRIES (64),
    .TIMEOUT     (8'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_v      (sel_v),
    .sel_rid    (sel_rid),
    .sel_unit   (sel_unit),
    .flush      (flush),
    .fu_done    (fu_done),
    .fu_full    (fu_full),
    .issued_v   (issued_v),
    .issued_rid (issued_rid),
    .sel_nack   (sel_nack),
    .nack_rid   (nack_rid),
    .fu_go      (fu_go),
    .fu_rid     (fu_rid),
    .cmp_v      (cmp_v),
    .cmp_err    (cmp_err),
    .cmp_rid    (cmp_rid),
    .fu_timeout (fu_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [81:0] w_all_out;
  assign w_all_out = {fu_full, issued_v, issued_rid, sel_nack, nack_rid, fu_go,
                      fu_rid, cmp_v, cmp_err, cmp_rid, fu_timeout};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [5:0] rid, input logic [1:0] unit);
    sel_v    = 1'b1;
    sel_rid  = rid;
    sel_unit = unit;
  endtask

  initial begin
    rst_n    = 1'b0;
    sel_v    = 1'b0;
    sel_rid  = 6'd0;
    sel_unit = 2'd0;
    flush    = 1'b0;
    fu_done  = 4'd0;
    step();
    step();
    chk("reset_outputs", 128'(w_all_out), 128'd0);
    rst_n = 1'b1;

    // ---------------- basic dispatch: rid 5 to ALU0 ----------------
    sel(6'd5, 2'd0);
    step();
    sel_v = 1'b0;
    chk("basic_issued_v",   128'(issued_v), 128'd1);
    chk("basic_issued_rid", 128'(issued_rid), 128'd5);
    chk("basic_go",         128'(fu_go), 128'b0001);
    chk("basic_fu_rid",     128'(fu_rid[5:0]), 128'd5);
    step();
    chk("basic_go_pulse",   128'(fu_go), 128'd0);
    chk("basic_issued_pulse", 128'(issued_v), 128'd0);
    step();
    step();
    chk("basic_rid_held",   128'(fu_rid[5:0]), 128'd5);
    fu_done = 4'b0001;
    step();
    fu_done = 4'b0000;
    chk("basic_cmp_v",   128'(cmp_v), 128'b0001);
    chk("basic_cmp_rid", 128'(cmp_rid[5:0]), 128'd5);
    chk("basic_cmp_err", 128'(cmp_err), 128'd0);
    step();
    chk("basic_cmp_pulse", 128'(cmp_v), 128'd0);

    // ---------------- full / nack on MEM (unit 2) ----------------
    sel(6'd9, 2'd2);
    step();
    chk("full_go9", 128'(fu_rid[17:12]), 128'd9);
    sel(6'd10, 2'd2);
    step();
    chk("full_issue10", 128'({issued_v, issued_rid}), 128'({1'b1, 6'd10}));
    chk("full_not_yet", 128'(fu_full[2]), 128'd0);
    sel(6'd11, 2'd2);
    step();
    chk("full_issue11", 128'({issued_v, issued_rid}), 128'({1'b1, 6'd11}));
    chk("full_flag",    128'(fu_full[2]), 128'd1);
    sel(6'd12, 2'd2);
    fu_done = 4'b0100;
    step();
    sel_v   = 1'b0;
    fu_done = 4'b0000;
    chk("nack_v",        128'(sel_nack), 128'd1);
    chk("nack_rid",      128'(nack_rid), 128'd12);
    chk("nack_no_issue", 128'(issued_v), 128'd0);
    chk("mem_cmp9",      128'({cmp_v[2], cmp_err[2], cmp_rid[17:12]}), 128'({1'b1, 1'b0, 6'd9}));
    chk("mem_bubble",    128'(fu_go), 128'd0);
    step();
    chk("mem_go10",      128'({fu_go, fu_rid[17:12]}), 128'({4'b0100, 6'd10}));
    chk("mem_unfull",    128'(fu_full[2]), 128'd0);
    fu_done = 4'b0100;
    step();
    fu_done = 4'b0000;
    chk("mem_cmp10",     128'({cmp_v[2], cmp_rid[17:12]}), 128'({1'b1, 6'd10}));
    step();
    chk("mem_go11",      128'({fu_go, fu_rid[17:12]}), 128'({4'b0100, 6'd11}));
    fu_done = 4'b0100;
    step();
    fu_done = 4'b0000;
    chk("mem_cmp11",     128'({cmp_v[2], cmp_rid[17:12]}), 128'({1'b1, 6'd11}));
    step();

    // ---------------- flush with FPU (unit 3) busy and queued ----------------
    sel(6'd20, 2'd3);
    step();
    chk("fpu_go20", 128'({fu_go, fu_rid[23:18]}), 128'({4'b1000, 6'd20}));
    sel(6'd21, 2'd3);
    step();
    sel_v = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_unfull", 128'(fu_full), 128'd0);
    fu_done = 4'b1000;
    step();
    fu_done = 4'b0000;
    chk("flush_no_cmp", 128'(cmp_v), 128'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_no_go21", 128'(fu_go), 128'd0);
    end
    sel(6'd22, 2'd3);
    step();
    sel_v = 1'b0;
    chk("fpu_go22", 128'({fu_go, fu_rid[23:18]}), 128'({4'b1000, 6'd22}));
    fu_done = 4'b1000;
    step();
    fu_done = 4'b0000;
    chk("fpu_cmp22", 128'({cmp_v, cmp_err, cmp_rid[23:18]}), 128'({4'b1000, 4'b0000, 6'd22}));

    // ---------------- flush vs select in the same cycle ----------------
    sel(6'd7, 2'd0);
    flush = 1'b1;
    step();
    sel_v = 1'b0;
    flush = 1'b0;
    chk("fvs_no_issue", 128'({issued_v, sel_nack}), 128'd0);
    chk("fvs_no_go",    128'(fu_go), 128'd0);
    step();
    chk("fvs_no_go_late", 128'(fu_go), 128'd0);

    // ---------------- watchdog timeout on ALU1 ----------------
    sel(6'd33, 2'd1);
    step();
    sel_v = 1'b0;
    chk("to_go33", 128'({fu_go, fu_rid[11:6]}), 128'({4'b0010, 6'd33}));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("to_not_yet", 128'({cmp_v[1], fu_timeout[1]}), 128'd0);
    end
    step();
    chk("to_cmp", 128'({cmp_v[1], cmp_err[1], cmp_rid[11:6]}), 128'({1'b1, 1'b1, 6'd33}));
    chk("to_flag", 128'(fu_timeout), 128'b0010);
    fu_done = 4'b0010;
    step();
    fu_done = 4'b0000;
    chk("to_idle_done_ignored", 128'(cmp_v), 128'd0);
    step();
    chk("to_sticky", 128'(fu_timeout[1]), 128'd1);

    // ---------------- reset mid-operation on ALU0 ----------------
    sel(6'd40, 2'd0);
    step();
    sel(6'd41, 2'd0);
    step();
    sel(6'd42, 2'd0);
    step();
    sel_v = 1'b0;
    chk("rst_pre_full", 128'(fu_full[0]), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 128'(w_all_out), 128'd0);
    step();
    rst_n = 1'b1;
    fu_done = 4'b0001;
    step();
    fu_done = 4'b0000;
    chk("rst_done_ignored", 128'({cmp_v, fu_go}), 128'd0);
    step();
    chk("rst_fifo_empty", 128'({fu_go, fu_full}), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
